sub_8bit: RTL and testbench

SUB_8BIT -- requirements
Module: sub_8bit

---
 rtl/sub_8bit.sv | 60 ++++++
 tb/tb_sub_8bit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sub_8bit.sv
// Registered N-bit two's-complement subtractor: S <= A - B, built as A + ~B + 1 on a ripple chain.
// Optional macro SUB_8BIT_SAT_EN clamps S on signed overflow instead of wrapping.
module sub_8bit #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] S
);

   logic [N-1:0] b_inv;
   logic [N-1:0] sum;
   logic [N:0]   carry;
   logic         carry_out;
   logic         borrow;
   logic         overflow;
   logic [N-1:0] d_next;
   logic         unused_flags;

   assign b_inv    = ~B;
   assign carry[0] = 1'b1;

   // One full-adder cell per bit; carry[i+1] is the cout of cell i.
   for (genvar i = 0; i < N; i++) begin : g_chain
      logic fa_a, fa_b, fa_cin;
      assign fa_a         = A[i];
      assign fa_b         = b_inv[i];
      assign fa_cin       = carry[i];
      assign sum[i]       = fa_a ^ fa_b ^ fa_cin;
      assign carry[i+1]   = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
   end

   assign carry_out = carry[N];
   assign borrow    = ~carry_out;
   assign overflow  = carry[N-1] ^ carry[N];

`ifdef SUB_8BIT_SAT_EN
   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

   // Overflow direction follows the sign of A.
   assign d_next = overflow ? (A[N-1] ? MAX_NEG : MAX_POS) : sum;
`else
   assign d_next = sum;
`endif

   // Flags are observable internally only; keep them from dangling.
   assign unused_flags = ^{borrow, overflow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S <= '0;
      end else begin
         S <= d_next;
      end
   end

endmodule

// File: tb/tb_sub_8bit.sv
// Scoreboard bench for sub_8bit (N = 8): driver pushes expected results, monitor pops and compares.
module tb_sub_8bit;

`ifdef SUB_8BIT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [7:0] exp;
      logic [7:0] a;
      logic [7:0] b;
      string      name;
   } item_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] s;

   item_t q[$];
   int checks = 0;
   int errors = 0;

   sub_8bit #(.N(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (a),
      .B    (b),
      .S    (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
      int d;
      logic [7:0] r;
      d = int'($signed(x)) - int'($signed(y));
      r = d[7:0];
      if (SAT && d > 127)  r = 8'h7F;
      if (SAT && d < -128) r = 8'h80;
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: S=%02h expected %02h", name, act, exp);
      end
   endtask

   // Called just after a negedge: inputs are sampled at the following posedge.
   task automatic drive(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp);
      item_t it;
      a = x;
      b = y;
      it.exp  = exp;
      it.a    = x;
      it.b    = y;
      it.name = name;
      q.push_back(it);
   endtask

   // Monitor: a result is due one edge after each push.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            it = q.pop_front();
            check($sformatf("%s A=%02h B=%02h", it.name, it.a, it.b), s, it.exp);
         end
      end
   end

   localparam int ND = 9;
   logic [7:0] va   [ND] = '{8'd5,  8'd30, 8'd127, 8'h80, 8'h07, 8'h55, 8'h03, 8'h80, 8'hFF};
   logic [7:0] vb   [ND] = '{8'd10, 8'hF6, 8'hFF,  8'h01, 8'h07, 8'h00, 8'h80, 8'h80, 8'h80};
   logic [7:0] vwr  [ND] = '{8'hFB, 8'h28, 8'h80,  8'h7F, 8'h00, 8'h55, 8'h83, 8'h00, 8'h7F};
   logic [7:0] vsat [ND] = '{8'hFB, 8'h28, 8'h7F,  8'h80, 8'h00, 8'h55, 8'h7F, 8'h00, 8'h7F};

   initial begin
      logic [7:0] ra, rb;
      int budget;
      rst_n = 1'b1;
      a = 8'h00;
      b = 8'h00;
      #1 rst_n = 1'b0;
      #2 check("reset_init", s, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < ND; i++) begin
         drive($sformatf("dir%0d", i), va[i], vb[i], SAT ? vsat[i] : vwr[i]);
         @(negedge clk);
      end

      // Async reset while S holds 0x28.
      drive("pre_reset", 8'd30, 8'hF6, 8'h28);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("reset_async", s, 8'h00);
      @(posedge clk);
      #1 check("reset_hold_edge", s, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("reset_released_no_edge", s, 8'h00);
      drive("post_reset", 8'd30, 8'hF6, 8'h28);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         drive($sformatf("rand%0d", i), ra, rb, ref_sub(ra, rb));
         @(negedge clk);
      end

      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
